// File: rtl/paillier_result_arbiter.sv
// Drains the Paillier per-block result FIFOs onto one K-bit stream in N-beat bursts.
// Build option: define PAILLIER_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority instead of round-robin.

module paillier_arb_req_lane #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic [CW-1:0] cnt,
  output logic          req
);
  assign req = (cnt >= CW'(N));
endmodule

module paillier_result_arbiter #(
  parameter int BLOCK_COUNT = 8,
  parameter int K           = 256,
  parameter int N           = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [BLOCK_COUNT*($clog2(N)+1)-1:0] rd_cnt,
  input  logic [BLOCK_COUNT*K-1:0]             rd_dout,
  output logic [BLOCK_COUNT-1:0]               rd_rdy,
  output logic [K-1:0]                         out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [$clog2(BLOCK_COUNT)-1:0]       out_blk,
  output logic                                 busy,
  output logic [31:0]                          bursts_done
);
  localparam int CW = $clog2(N) + 1;
  localparam int BW = $clog2(BLOCK_COUNT);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [BLOCK_COUNT-1:0] req;
  logic [BW-1:0]          grant, grant_nxt, ptr;
  logic [CW-1:0]          beats_left;
  logic                   pop, done;

  for (genvar i = 0; i < BLOCK_COUNT; i++) begin : g_lane
    paillier_arb_req_lane #(.N(N), .CW(CW)) u_lane (
      .cnt (rd_cnt[i*CW +: CW]),
      .req (req[i])
    );
  end

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    grant_nxt = '0;
`ifdef PAILLIER_ARB_FIXED_PRIO_EN
    for (int i = BLOCK_COUNT - 1; i >= 0; i--)
      if (req[i]) grant_nxt = BW'(i);
`else
    for (int k = BLOCK_COUNT; k >= 1; k--)
      if (req[(int'(ptr) + k) % BLOCK_COUNT]) grant_nxt = BW'((int'(ptr) + k) % BLOCK_COUNT);
`endif
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (enable && |req) state_nxt = DRAIN;
      DRAIN: begin
        pop  = (beats_left != '0) && (!out_valid || out_ready);
        done = out_valid && out_ready && out_last;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_rdy = pop ? (BLOCK_COUNT'(1) << grant) : '0;
  assign busy   = (state == DRAIN);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant       <= '0;
      ptr         <= BW'(BLOCK_COUNT - 1);
      beats_left  <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_blk     <= '0;
      bursts_done <= '0;
    end else begin
      if (state == IDLE && state_nxt == DRAIN) begin
        grant      <= grant_nxt;
        beats_left <= CW'(N);
      end
      if (pop) begin
        out_data   <= rd_dout[int'(grant)*K +: K];
        out_valid  <= 1'b1;
        out_blk    <= grant;
        out_last   <= (beats_left == CW'(1));
        beats_left <= beats_left - CW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (done) begin
          out_last    <= 1'b0;
          bursts_done <= bursts_done + 32'd1;
          ptr         <= grant;
        end
      end
    end
endmodule

// File: doc/paillier_result_arbiter.md
Name: paillier_result_arbiter

Overview:
- Drains the per-block result FIFOs of the Paillier engine array onto one shared K-bit stream. The stream feeds the AXI-FULL write path.
- Round-robin arbitrates among blocks whose FIFO holds at least N results. Pops exactly N words from the granted FIFO, tagging each beat with the block index and a last flag.
- Sits between the BLOCK_COUNT result FIFOs and the AXI write-burst generator. One grant equals one N-beat burst.

Parameters:
- BLOCK_COUNT, 8, number of Paillier blocks/FIFOs (>=2).
- K, 256, data width of one result word.
- N, 16, words per burst; FIFO count width is $clog2(N)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- enable  in  1  permits new grants; an in-flight burst always completes.
- rd_cnt  in  BLOCK_COUNT*($clog2(N)+1)  flattened FIFO occupancy; slice i belongs to block i.
- rd_dout  in  BLOCK_COUNT*K  flattened FIFO head words (first-word fall-through).
- rd_rdy  out  BLOCK_COUNT  per-FIFO pop strobe; at most one bit high.
- out_data  out  K  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final (Nth) beat of burst.
- out_blk  out  $clog2(BLOCK_COUNT)  source block of current beat.
- busy  out  1  burst in progress (state DRAIN).
- bursts_done  out  32  completed-burst counter.

Behaviour:
- FIFO contract: rd_dout slice i is valid whenever its rd_cnt > 0. A pop takes effect in the same cycle rd_rdy[i] is high. Drain starts only when rd_cnt >= N, so underflow is impossible.
- Reset values: state IDLE, rd_rdy 0, out_valid 0, out_last 0, out_data 0, out_blk 0, busy 0, bursts_done 0, beat counter 0, last-grant pointer BLOCK_COUNT-1 (block 0 wins first).
- req[i] = (rd_cnt slice i >= N).
- IDLE:
  - if enable && |req: register grant g = first requester after the last-grant pointer, cyclically.
  - load beats_left = N, move to DRAIN.
  - otherwise stay in IDLE.
- DRAIN:
  - pop = (beats_left != 0) && (!out_valid || out_ready).
  - rd_rdy[g] = pop (combinational from registered state).
  - On pop: out_data <= rd_dout slice g; out_valid <= 1; out_blk <= g; out_last <= (beats_left == 1); beats_left decrements.
  - On out_valid && out_ready without a pop: out_valid <= 0.
  - On out_valid && out_ready && out_last: bursts_done += 1 (wraps at 2^32); last-grant pointer <= g; state returns to IDLE; out_valid and out_last clear.
- Latency:
  - req seen in cycle t gives busy and first rd_rdy in t+1, and first out_valid in t+2.
  - With out_ready held high, N consecutive beats follow.
  - The burst's last handshake is followed by one IDLE cycle before the next grant (minimum 1-cycle gap between bursts).
- Backpressure: while out_valid && !out_ready, out_data, out_blk and out_last hold stable and rd_rdy is 0.
- Only g is sampled during DRAIN; requests from other blocks are ignored until IDLE.
- enable low: no grant from IDLE; an active burst runs to completion.
- rd_cnt > N: only N words are popped; the block may re-win after the others are served.
- Single requester: it is granted back-to-back, with the 1-cycle IDLE gap.
- rst asserted mid-burst: immediate return to reset values. Partially drained FIFO data is not recovered (software must re-run the task).

Optional Feature:
- Macro PAILLIER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, the lowest-index requester always wins; the last-grant pointer is not used.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Block 3 rd_cnt=16, others 0, out_ready=1:
  - required: rd_rdy[3] pulses 16 consecutive cycles.
  - required: 16 beats with out_blk=3, out_last only on beat 16.
  - required: bursts_done=1.
- Block 5 rd_cnt=15 for 50 cycles -> no rd_rdy, out_valid=0; raise to 16 -> burst starts 1 cycle later.
- Blocks 0, 2, 7 all at 16 from reset:
  - required: burst order 0,2,7; then with all refilled, order 0,2,7 again.
  - PAILLIER_ARB_FIXED_PRIO_EN build, block 0 refilled after each of its bursts: 0,0,... starves blocks 2 and 7.
- Block 1 at 16, out_ready toggles 1010... -> out_data and out_blk stable while stalled; exactly 16 pops, data order equals FIFO order.
- enable=0 with block 4 at 16 -> no grant; enable=1 for 1 cycle then 0 -> full 16-beat burst completes.
- rst pulse after beat 6 of a burst -> all outputs at reset values next cycle; after release, block 0 (if requesting) is granted first.
